// File: rtl/inst_fetch_queue.sv
// Instruction fetch/prefetch queue: sequential word reads into a small FIFO,
// presented to the decoder on a valid/take handshake. Optional FETCH_STATS_EN adds counters.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          AW       = 16,
  parameter int          DW       = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                   clock,
  input  logic                   resetn,
  output logic                   mem_rd,
  output logic [AW-1:0]          mem_addr,
  input  logic [DW-1:0]          mem_rdata,
  input  logic                   flush,
  input  logic [AW-1:0]          flush_target,
  input  logic                   halt,
  output logic [DW-1:0]          ifd,
  output logic [AW-1:0]          ifd_pc,
  output logic                   ifd_valid,
  input  logic                   ifd_take,
  output logic [$clog2(DEPTH):0] q_count
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]            stat_fetches,
  output logic [15:0]            stat_flushes
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HOLD} state_t;

  state_t        state, next_state;
  logic [AW-1:0] pc;
  logic [AW-1:0] infl_pc;
  logic          inflight;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [DW-1:0] data_mem [DEPTH];
  logic [AW-1:0] pc_mem   [DEPTH];

  logic issue, push, pop;

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_BOOT;
    else         state <= next_state;
  end

  // NOTE: combinational blocks assign a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = halt ? S_HOLD : S_RUN;
    end else begin
      case (state)
        S_BOOT, S_RUN: next_state = halt ? S_HOLD : S_RUN;
        S_HOLD:        next_state = halt ? S_HOLD : S_RUN;
        default:       next_state = S_BOOT;
      endcase
    end
  end

  // Counting the in-flight read as reserved guarantees every return has a free slot.
  always_comb begin
    issue     = (state == S_RUN) && !flush && ((count + CW'(inflight)) < DEPTH_C);
    push      = inflight && !flush;
    pop       = ifd_take && (count != '0) && !flush;
    mem_rd    = issue;
    mem_addr  = issue ? pc : '0;
    ifd_valid = (count != '0);
    ifd       = ifd_valid ? data_mem[head] : '0;
    ifd_pc    = ifd_valid ? pc_mem[head] : '0;
    q_count   = count;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pc       <= AW'(RESET_PC);
      infl_pc  <= '0;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (flush) begin
      pc       <= flush_target;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        infl_pc <= pc;
        pc      <= pc + AW'(1);
      end
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: entry storage has no reset; outputs are gated by ifd_valid so stale entries never leak.
  always_ff @(posedge clock) begin
    if (push) begin
      data_mem[tail] <= mem_rdata;
      pc_mem[tail]   <= infl_pc;
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stat_fetches <= '0;
      stat_flushes <= '0;
    end else begin
      if (push && (stat_fetches != 16'hFFFF)) stat_fetches <= stat_fetches + 16'd1;
      if (flush && (stat_flushes != 16'hFFFF)) stat_flushes <= stat_flushes + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata = '0;
  logic        flush = 1'b0;
  logic [15:0] flush_target = '0;
  logic        halt = 1'b0;
  logic [15:0] ifd;
  logic [15:0] ifd_pc;
  logic        ifd_valid;
  logic        ifd_take = 1'b0;
  logic [2:0]  q_count;
`ifdef FETCH_STATS_EN
  logic [15:0] stat_fetches;
  logic [15:0] stat_flushes;
`endif

  inst_fetch_queue #(.DEPTH(DEPTH), .AW(16), .DW(16), .RESET_PC(0)) dut (
    .clock(clock), .resetn(resetn),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .flush(flush), .flush_target(flush_target), .halt(halt),
    .ifd(ifd), .ifd_pc(ifd_pc), .ifd_valid(ifd_valid), .ifd_take(ifd_take),
    .q_count(q_count)
`ifdef FETCH_STATS_EN
    , .stat_fetches(stat_fetches), .stat_flushes(stat_flushes)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] word(input logic [15:0] a);
    return 16'hA000 + a;
  endfunction

  // Synchronous instruction memory: data one cycle after the strobe.
  always @(posedge clock) if (mem_rd) mem_rdata <= word(mem_addr);

  int checks = 0;
  int failures = 0;

  // Reference model: what is queued (by fetch address), what is outstanding, where fetch is.
  logic [15:0] m_q [$];
  logic [15:0] m_pc;
  logic [15:0] m_infl_pc;
  bit          m_inflight;
  bit          m_run;
  int          m_fetches;
  int          m_flushes;

  // Values sampled mid-cycle by the last call of cycle().
  logic        s_rd, s_valid;
  logic [15:0] s_addr, s_ifd, s_pc;
  logic [2:0]  s_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc       = 16'h0000;
    m_infl_pc  = 16'h0000;
    m_inflight = 1'b0;
    m_run      = 1'b0;
    m_fetches  = 0;
    m_flushes  = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".mem_rd"}, 32'(mem_rd), 32'd0);
    check({tag, ".mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, ".ifd"}, 32'(ifd), 32'd0);
    check({tag, ".ifd_pc"}, 32'(ifd_pc), 32'd0);
    check({tag, ".ifd_valid"}, 32'(ifd_valid), 32'd0);
    check({tag, ".q_count"}, 32'(q_count), 32'd0);
`ifdef FETCH_STATS_EN
    check({tag, ".stat_fetches"}, 32'(stat_fetches), 32'd0);
    check({tag, ".stat_flushes"}, 32'(stat_flushes), 32'd0);
`endif
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    @(posedge clock);
    #3 resetn = 1'b0;
    #1 check_zero_outputs("reset");
    model_reset();
    @(posedge clock);
    #2 resetn = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare against the model, then advance the model.
  task automatic cycle(input bit f, input logic [15:0] tgt, input bit h, input bit t);
    int n;
    bit exp_rd;
    @(negedge clock);
    flush = f; flush_target = tgt; halt = h; ifd_take = t;
    #1;
    n = m_q.size();
    exp_rd = m_run && ((n + int'(m_inflight)) < DEPTH) && !f;
    check("mem_rd", 32'(mem_rd), 32'(exp_rd));
    check("mem_addr", 32'(mem_addr), exp_rd ? 32'(m_pc) : 32'd0);
    check("ifd_valid", 32'(ifd_valid), 32'(n != 0));
    check("q_count", 32'(q_count), 32'(n));
    if (n != 0) begin
      check("ifd", 32'(ifd), 32'(word(m_q[0])));
      check("ifd_pc", 32'(ifd_pc), 32'(m_q[0]));
    end else begin
      check("ifd_idle", 32'(ifd), 32'd0);
      check("ifd_pc_idle", 32'(ifd_pc), 32'd0);
    end
    s_rd = mem_rd; s_addr = mem_addr; s_valid = ifd_valid;
    s_ifd = ifd; s_pc = ifd_pc; s_count = q_count;
    @(posedge clock);
    if (f) begin
      m_q.delete();
      m_inflight = 1'b0;
      m_pc = tgt;
      m_flushes++;
    end else begin
      if (t && n > 0) void'(m_q.pop_front());
      if (m_inflight) begin
        m_q.push_back(m_infl_pc);
        m_fetches++;
      end
      m_inflight = exp_rd;
      if (exp_rd) begin
        m_infl_pc = m_pc;
        m_pc = m_pc + 16'd1;
      end
    end
    m_run = !h;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int issues;
    int maxc;
    int drops;
    int halt_rd;
    logic [15:0] exp_seq;
    logic [15:0] last_pc;

    model_reset();
    #12 check_zero_outputs("por");

    // Fill with no consumer: four reads then the queue is full.
    do_reset();
    issues = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(0, 16'h0, 0, 0);
      issues += int'(s_rd);
    end
    check("fill.issues", 32'(issues), 32'd4);
    check("fill.q_count", 32'(s_count), 32'd4);
    check("fill.ifd", 32'(s_ifd), 32'hA000);
    check("fill.ifd_pc", 32'(s_pc), 32'd0);

    // Continuous consumer: one word per cycle, queue stays shallow.
    do_reset();
    maxc = 0; drops = 0; exp_seq = 16'h0;
    for (int i = 0; i < 16; i++) begin
      cycle(0, 16'h0, 0, 1);
      if (int'(s_count) > maxc) maxc = int'(s_count);
      if (i >= 1 && !s_rd) drops++;
      if (s_valid) begin
        check("stream.ifd_pc", 32'(s_pc), 32'(exp_seq));
        exp_seq = exp_seq + 16'd1;
      end
    end
    check("stream.max_le2", 32'(maxc <= 2), 32'd1);
    check("stream.rd_drops", 32'(drops), 32'd0);

    // Flush with three queued and one in flight.
    do_reset();
    repeat (5) cycle(0, 16'h0, 0, 0);
    cycle(1, 16'h0040, 0, 0);
    check("flush.pre_count", 32'(s_count), 32'd3);
    cycle(0, 16'h0, 0, 0);
    check("flush.valid_after", 32'(s_valid), 32'd0);
    check("flush.addr_after", 32'(s_addr), 32'h0040);
    for (int i = 0; i < 6 && !s_valid; i++) cycle(0, 16'h0, 0, 0);
    check("flush.first_valid", 32'(s_valid), 32'd1);
    check("flush.first_word", 32'(s_ifd), 32'hA040);

    // Flush and take together with the queue full.
    do_reset();
    repeat (7) cycle(0, 16'h0, 0, 0);
    check("ftake.full", 32'(s_count), 32'd4);
    cycle(1, 16'h0100, 0, 1);
    cycle(0, 16'h0, 0, 0);
    check("ftake.count_after", 32'(s_count), 32'd0);

    // Halt while draining: in-flight word lands, queue empties, fetch resumes in order.
    repeat (6) cycle(0, 16'h0, 0, 1);
    halt_rd = 0; last_pc = 16'h0;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 16'h0, 1, 1);
      if (i > 0) halt_rd += int'(s_rd);
      if (s_valid) last_pc = s_pc;
    end
    check("halt.no_rd", 32'(halt_rd), 32'd0);
    check("halt.drained", 32'(s_count), 32'd0);
    cycle(0, 16'h0, 0, 1);
    cycle(0, 16'h0, 0, 1);
    check("halt.resume_rd", 32'(s_rd), 32'd1);
    check("halt.resume_addr", 32'(s_addr), 32'(last_pc + 16'd1));

    // Mid-fetch asynchronous reset, then restart from RESET_PC.
    repeat (3) cycle(0, 16'h0, 0, 0);
    do_reset();
    cycle(0, 16'h0, 0, 0);
    cycle(0, 16'h0, 0, 0);
    check("rst.restart_rd", 32'(s_rd), 32'd1);
    check("rst.restart_addr", 32'(s_addr), 32'd0);

`ifdef FETCH_STATS_EN
    // Ten enqueues and two flushes.
    do_reset();
    repeat (7) cycle(0, 16'h0, 0, 1);
    cycle(1, 16'h0200, 0, 1);
    repeat (6) cycle(0, 16'h0, 0, 1);
    cycle(1, 16'h0300, 0, 1);
    cycle(0, 16'h0, 0, 1);
    #1;
    check("stats.fetches", 32'(stat_fetches), 32'd10);
    check("stats.flushes", 32'(stat_flushes), 32'd2);
`endif

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(15) == 0), 16'($urandom), ($urandom_range(7) == 0), $urandom_range(1) == 1);
    end
`ifdef FETCH_STATS_EN
    #1;
    check("rand.stat_fetches", 32'(stat_fetches), 32'(m_fetches));
    check("rand.stat_flushes", 32'(stat_flushes), 32'(m_flushes));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
